// File: rtl/spi_fb_writer.sv
`timescale 1ns/1ps
// spi_fb_writer
//   SPI mode-0 slave that turns host command frames into framebuffer writes.
//   Frame commands: 0x01 SET_ADDR (ADDR_H, ADDR_L), 0x02 WRITE (PIX_H, PIX_L pairs),
//   0x03 FILL (FILL_H, FILL_L; only when FB_FILL_EN is defined). Anything else
//   pulses frame_err and the rest of the frame is ignored.
//   Build option: define FB_FILL_EN to enable the FILL command and the busy output.
// Ports
//   clk        system clock, everything on posedge
//   rst_n      asynchronous active-low reset
//   spi_sck    SPI clock (async to clk, at most clk/8)
//   spi_cs_n   SPI chip select, active low
//   spi_mosi   SPI data, MSB first, sampled on sck rise
//   fb_wen     framebuffer write strobe
//   fb_addr    framebuffer write address
//   fb_wdata   framebuffer write data (RGB565)
//   busy       high while a fill sweep runs
//   frame_err  one-clk pulse on protocol error
module spi_fb_writer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              fb_wen,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_PIX_H, ST_PIX_L, ST_DISCARD
`ifdef FB_FILL_EN
    , ST_FILL_H, ST_FILL_L, ST_FILLING
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  // Synchroniser chain, packed as {mosi, cs_n, sck}; cs_n resets to idle-high.
  logic [2:0] sync_q [SYNC_STAGES];
  logic       sck_s, cs_s, mosi_s, sck_prev_q, sck_rise;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d, byte_w;
  logic                  byte_valid;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-9:0]     addr_h_q, addr_h_d;
  logic [7:0]            pix_h_q, pix_h_d;
  logic                  wen_q, wen_d, err_q, err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  in_fill;
`ifdef FB_FILL_EN
  logic [7:0]            fill_h_q, fill_h_d;
  logic                  busy_q, busy_d;
`endif

  assign sck_s    = sync_q[SYNC_STAGES-1][0];
  assign cs_s     = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][2];
  assign sck_rise = sck_s & ~sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b010;
      sck_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {spi_mosi, spi_cs_n, spi_sck};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_prev_q <= sck_s;
    end
  end

  // Byte assembly: the completed byte is presented combinationally in the
  // cycle of the 8th rise so the FSM consumes it without an extra stage.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_valid = 1'b0;
    byte_w     = {shift_q[6:0], mosi_s};
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d    = byte_w;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_valid = (bit_cnt_q == 3'd7);
    end
  end

`ifdef FB_FILL_EN
  assign in_fill = (state_q == ST_FILLING);
`else
  assign in_fill = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs_s && !in_fill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_CMD;
        ST_CMD:
          if (byte_valid) begin
            case (byte_w)
              8'h01:   state_d = ST_ADDR_H;
              8'h02:   state_d = ST_PIX_H;
`ifdef FB_FILL_EN
              8'h03:   state_d = ST_FILL_H;
`endif
              default: state_d = ST_DISCARD;
            endcase
          end
        ST_ADDR_H:  if (byte_valid) state_d = ST_ADDR_L;
        ST_ADDR_L:  if (byte_valid) state_d = ST_CMD;
        ST_PIX_H:   if (byte_valid) state_d = ST_PIX_L;
        ST_PIX_L:   if (byte_valid) state_d = ST_PIX_H;
        ST_DISCARD: state_d = ST_DISCARD;
`ifdef FB_FILL_EN
        ST_FILL_H:  if (byte_valid) state_d = ST_FILL_L;
        ST_FILL_L:  if (byte_valid) state_d = ST_FILLING;
        // The address currently on fb_addr is the sweep position.
        ST_FILLING: if (addr_q == ADDR_LAST) state_d = cs_s ? ST_IDLE : ST_DISCARD;
`endif
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next-state logic; outputs are registered so a byte
  // consumed in cycle N shows up on the framebuffer port in cycle N+1.
  always_comb begin
    wen_d    = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    addr_h_d = addr_h_q;
    pix_h_d  = pix_h_q;
`ifdef FB_FILL_EN
    fill_h_d = fill_h_q;
    busy_d   = 1'b0;
`endif
    case (state_q)
      ST_CMD:
        if (byte_valid) begin
          case (byte_w)
            8'h01, 8'h02: err_d = 1'b0;
`ifdef FB_FILL_EN
            8'h03:        err_d = 1'b0;
`endif
            default:      err_d = 1'b1;
          endcase
        end
      ST_ADDR_H: if (byte_valid) addr_h_d = byte_w[ADDR_W-9:0];
      ST_ADDR_L: if (byte_valid) ptr_d = {addr_h_q, byte_w};
      ST_PIX_H:  if (byte_valid) pix_h_d = byte_w;
      ST_PIX_L:
        if (byte_valid) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdata_d = {pix_h_q, byte_w};
          ptr_d   = ptr_q + 1'b1;
        end
`ifdef FB_FILL_EN
      ST_FILL_H: if (byte_valid) fill_h_d = byte_w;
      ST_FILL_L:
        if (byte_valid) begin
          wen_d   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
          wdata_d = {fill_h_q, byte_w};
        end
      ST_FILLING: begin
        err_d = byte_valid;
        if (addr_q == ADDR_LAST) begin
          ptr_d = '0;
        end else begin
          wen_d  = 1'b1;
          busy_d = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      addr_h_q  <= '0;
      pix_h_q   <= '0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef FB_FILL_EN
      fill_h_q  <= '0;
      busy_q    <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      addr_h_q  <= addr_h_d;
      pix_h_q   <= pix_h_d;
      wen_q     <= wen_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef FB_FILL_EN
      fill_h_q  <= fill_h_d;
      busy_q    <= busy_d;
`endif
    end
  end

  assign fb_wen    = wen_q;
  assign fb_addr   = addr_q;
  assign fb_wdata  = wdata_q;
  assign frame_err = err_q;
`ifdef FB_FILL_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fb_writer.sv
`timescale 1ns/1ps
module tb_spi_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        fb_wen;
  logic [9:0]  fb_addr;
  logic [15:0] fb_wdata;
  logic        busy;
  logic        frame_err;

  spi_fb_writer #(.ADDR_W(10), .DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .fb_wen(fb_wen), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor: only this block writes these; the stimulus takes deltas.
  logic [9:0]  wq_addr [$];
  logic [15:0] wq_data [$];
  int err_cnt = 0, err_long = 0, consec = 0, busy_cnt = 0;
  logic wen_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (fb_wen) begin
      wq_addr.push_back(fb_addr);
      wq_data.push_back(fb_wdata);
    end
    if (fb_wen && wen_prev) consec++;
    if (frame_err) err_cnt++;
    if (frame_err && err_prev) err_long++;
    if (busy) busy_cnt++;
    wen_prev = fb_wen;
    err_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [9:0] a, input logic [15:0] d);
    if (idx < wq_addr.size()) begin
      check({tag, "_addr"}, 32'(wq_addr[idx]), 32'(a));
      check({tag, "_data"}, 32'(wq_data[idx]), 32'(d));
    end else begin
      check({tag, "_missing"}, 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #50 spi_sck = 1'b1;
      #50 spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #100 spi_cs_n = 1'b1;
    #300;
  endtask

  task automatic send_frame(input logic [7:0] b [8], input int n);
    frame_start();
    for (int i = 0; i < n; i++) spi_byte(b[i]);
    frame_end();
  endtask

  int wb, eb, cb, bb, bad, t;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen",   32'(fb_wen), 32'h0);
    check("rst_addr",  32'(fb_addr), 32'h0);
    check("rst_wdata", 32'(fb_wdata), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_err",   32'(frame_err), 32'h0);
    rst_n = 1'b1;
    #200;

    // SET_ADDR 5, then two pixels
    wb = wq_addr.size(); cb = consec;
    send_frame('{8'h01, 8'h05 & 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h02, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h00, 8'h00}, 5);
    check("t1_count", 32'(wq_addr.size() - wb), 32'd2);
    check_wr("t1_w0", wb, 10'd5, 16'hF800);
    check_wr("t1_w1", wb + 1, 10'd6, 16'h07E0);
    check("t1_single_pulse", 32'(consec - cb), 32'd0);

    // Address wrap 1023 -> 0 -> 1
    wb = wq_addr.size();
    send_frame('{8'h01, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00}, 7);
    check("t2_count", 32'(wq_addr.size() - wb), 32'd3);
    check_wr("t2_w0", wb, 10'd1023, 16'h0001);
    check_wr("t2_w1", wb + 1, 10'd0, 16'h0002);
    check_wr("t2_w2", wb + 2, 10'd1, 16'h0003);

    // Dangling high byte dropped; pointer continues
    wb = wq_addr.size();
    send_frame('{8'h02, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    check("t3_count", 32'(wq_addr.size() - wb), 32'd1);
    check_wr("t3_w0", wb, 10'd2, 16'h1234);
    wb = wq_addr.size();
    send_frame('{8'h02, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check_wr("t3_next", wb, 10'd3, 16'hAA55);

    // Unknown command
    wb = wq_addr.size(); eb = err_cnt; t = err_long;
    frame_start();
    spi_byte(8'h7F);
    #100;
    check("t4_err_after_cmd", 32'(err_cnt - eb), 32'd1);
    spi_byte(8'hAA);
    spi_byte(8'hBB);
    frame_end();
    check("t4_err_total", 32'(err_cnt - eb), 32'd1);
    check("t4_err_width", 32'(err_long - t), 32'd0);
    check("t4_no_write", 32'(wq_addr.size() - wb), 32'd0);
    send_frame('{8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h02, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check_wr("t4_recover", wb, 10'h020, 16'hBEEF);

`ifdef FB_FILL_EN
    // Fill sweep with a byte arriving mid-sweep
    wb = wq_addr.size(); eb = err_cnt; bb = busy_cnt;
    frame_start();
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h1F);
    for (t = 0; t < 50 && !busy; t++) @(posedge clk);
    check("t5_busy_seen", 32'(busy), 32'h1);
    spi_byte(8'h55);
    for (t = 0; t < 1500 && busy; t++) @(posedge clk);
    check("t5_busy_drop", 32'(busy), 32'h0);
    frame_end();
    check("t5_busy_len", 32'(busy_cnt - bb), 32'd1024);
    check("t5_count", 32'(wq_addr.size() - wb), 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wb + i >= wq_addr.size() || wq_addr[wb + i] != 10'(i) || wq_data[wb + i] != 16'h001F) bad++;
    check("t5_fill_bad", 32'(bad), 32'd0);
    check("t5_err", 32'(err_cnt - eb), 32'd1);
    wb = wq_addr.size();
    send_frame('{8'h02, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check_wr("t5_after", wb, 10'd0, 16'hABCD);
`else
    // 0x03 is unknown without the fill option
    wb = wq_addr.size(); eb = err_cnt; bb = busy_cnt;
    send_frame('{8'h03, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check("t5_err", 32'(err_cnt - eb), 32'd1);
    check("t5_no_busy", 32'(busy_cnt - bb), 32'd0);
    check("t5_no_write", 32'(wq_addr.size() - wb), 32'd0);
`endif

    // Reset during the 4th sck of a byte
    frame_start();
    spi_byte(8'h02);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b1;
      #50 spi_sck = 1'b1;
      if (i < 3) #50 spi_sck = 1'b0;
    end
    #20 rst_n = 1'b0;
    #1;
    check("t6_rst_wen",   32'(fb_wen), 32'h0);
    check("t6_rst_addr",  32'(fb_addr), 32'h0);
    check("t6_rst_wdata", 32'(fb_wdata), 32'h0);
    spi_sck = 1'b0; spi_cs_n = 1'b1;
    #100 rst_n = 1'b1;
    #200;
    wb = wq_addr.size();
    send_frame('{8'h02, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check_wr("t6_ptr_reset", wb, 10'd0, 16'h5AA5);
    send_frame('{8'h01, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h02, 8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check_wr("t6_w9", wb + 1, 10'd9, 16'hC33C);

`ifdef FB_FILL_EN
    // Reset during a fill sweep
    frame_start();
    spi_byte(8'h03); spi_byte(8'h12); spi_byte(8'h34);
    for (t = 0; t < 50 && !busy; t++) @(posedge clk);
    check("t6_fill_busy", 32'(busy), 32'h1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_fill_rst_busy", 32'(busy), 32'h0);
    check("t6_fill_rst_wen",  32'(fb_wen), 32'h0);
    check("t6_fill_rst_addr", 32'(fb_addr), 32'h0);
    spi_cs_n = 1'b1;
    #100 rst_n = 1'b1;
    #200;
    wb = wq_addr.size();
    send_frame('{8'h01, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    send_frame('{8'h02, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    check("t6_fill_count", 32'(wq_addr.size() - wb), 32'd1);
    check_wr("t6_fill_w9", wb, 10'd9, 16'h0FF0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
